interrupt_sequencer: RTL and testbench

//   Multi-cycle controller that takes an external interrupt at an instruction

---
 rtl/interrupt_sequencer.sv | 161 ++++++++++++++++
 tb/tb_interrupt_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer: takes a pending external interrupt at an instruction
// boundary and walks the stack/memory port through the entry sequence
// (push PC low, push PC high, push CCR, fetch vector low/high, load PC).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | pipeline owns the port; waiting for pending & boundary
// PUSH_PCL | pushing saved_pc low word
// PUSH_PCH | pushing saved_pc high word
// PUSH_CCR | pushing zero-extended saved flags
// FETCH_VL | reading ISR vector low word at VEC_ADDR
// FETCH_VH | reading ISR vector high word at VEC_ADDR+1
// LOAD_PC  | loading ISR entry into fetch PC, acknowledging interrupt
module interrupt_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 20,
    parameter logic [ADDR_WIDTH-1:0] VEC_ADDR = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      interrupt,
    input  logic                      inst_boundary,
    input  logic                      rti_done,
    input  logic [2*DATA_WIDTH-1:0]   resume_pc,
    input  logic [2:0]                ccr,
    input  logic                      mem_ready,
    input  logic [DATA_WIDTH-1:0]     mem_rdata,
    output logic                      freeze,
    output logic                      push_en,
    output logic [DATA_WIDTH-1:0]     push_data,
    output logic                      mem_rd_en,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    output logic                      pc_load,
    output logic [2*DATA_WIDTH-1:0]   pc_load_val,
    output logic                      int_ack,
    output logic                      in_isr
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PUSH_PCL = 3'd1,
        PUSH_PCH = 3'd2,
        PUSH_CCR = 3'd3,
        FETCH_VL = 3'd4,
        FETCH_VH = 3'd5,
        LOAD_PC  = 3'd6
    } state_t;

    // The high vector word sits one above the low word, wrapping at the top
    // of the address space.
    localparam logic [ADDR_WIDTH-1:0] VEC_ADDR_HI = VEC_ADDR + 1'b1;

    state_t                    state;
    state_t                    next_state;
    logic                      pending;
    logic                      isr_q;
    logic [2*DATA_WIDTH-1:0]   saved_pc;
    logic [2:0]                saved_ccr;
    logic [DATA_WIDTH-1:0]     vec_lo;
    logic [DATA_WIDTH-1:0]     vec_hi;
    logic                      leave_idle;

    assign leave_idle = (state == IDLE) && pending && inst_boundary && !isr_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Pending request: a request on the departure edge survives so it is
    // not lost when the current one is being serviced.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             pending <= 1'b0;
        else if (leave_idle) pending <= interrupt;
        else if (interrupt)  pending <= 1'b1;
    end

    // Snapshot return PC and flags at the moment the sequence is entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            saved_pc  <= '0;
            saved_ccr <= '0;
        end else if (leave_idle) begin
            saved_pc  <= resume_pc;
            saved_ccr <= ccr;
        end
    end

    // Capture vector words as the memory accepts each read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_lo <= '0;
            vec_hi <= '0;
        end else if (mem_ready) begin
            if (state == FETCH_VL) vec_lo <= mem_rdata;
            if (state == FETCH_VH) vec_hi <= mem_rdata;
        end
    end

    // ISR flag: entering the ISR takes priority over a coincident RTI.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                   isr_q <= 1'b0;
        else if (state == LOAD_PC) isr_q <= 1'b1;
        else if (rti_done)         isr_q <= 1'b0;
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        next_state  = state;
        freeze      = 1'b1;
        push_en     = 1'b0;
        push_data   = '0;
        mem_rd_en   = 1'b0;
        mem_addr    = '0;
        pc_load     = 1'b0;
        pc_load_val = '0;
        int_ack     = 1'b0;
        in_isr      = isr_q;
        case (state)
            IDLE: begin
                freeze = 1'b0;
                if (leave_idle) next_state = PUSH_PCL;
            end
            PUSH_PCL: begin
                push_en   = 1'b1;
                push_data = saved_pc[DATA_WIDTH-1:0];
                if (mem_ready) next_state = PUSH_PCH;
            end
            PUSH_PCH: begin
                push_en   = 1'b1;
                push_data = saved_pc[2*DATA_WIDTH-1:DATA_WIDTH];
                if (mem_ready) next_state = PUSH_CCR;
            end
            PUSH_CCR: begin
                push_en   = 1'b1;
                push_data = {{(DATA_WIDTH-3){1'b0}}, saved_ccr};
                if (mem_ready) next_state = FETCH_VL;
            end
            FETCH_VL: begin
                mem_rd_en = 1'b1;
                mem_addr  = VEC_ADDR;
                if (mem_ready) next_state = FETCH_VH;
            end
            FETCH_VH: begin
                mem_rd_en = 1'b1;
                mem_addr  = VEC_ADDR_HI;
                if (mem_ready) next_state = LOAD_PC;
            end
            LOAD_PC: begin
                pc_load     = 1'b1;
                pc_load_val = {vec_hi, vec_lo};
                int_ack     = 1'b1;
                in_isr      = 1'b1;
                next_state  = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Bench for interrupt_sequencer: directed scenarios plus a randomized run,
// checked against a transaction-level model and expectation queues.
module tb_interrupt_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        interrupt = 1'b0;
    logic        inst_boundary = 1'b0;
    logic        rti_done = 1'b0;
    logic [31:0] resume_pc = '0;
    logic [2:0]  ccr = '0;
    logic        mem_ready = 1'b1;
    logic [15:0] mem_rdata, mem_rdata2;

    logic        freeze, push_en, mem_rd_en, pc_load, int_ack, in_isr;
    logic [15:0] push_data;
    logic [19:0] mem_addr;
    logic [31:0] pc_load_val;
    logic        freeze2, push_en2, mem_rd_en2, pc_load2, int_ack2, in_isr2;
    logic [15:0] push_data2;
    logic [19:0] mem_addr2;
    logic [31:0] pc_load_val2;

    logic        fixed_mem = 1'b1;
    logic [15:0] mem_seed = 16'h0;

    int n_cmp = 0;
    int n_fail = 0;
    int acks_seen = 0;
    int pushes_seen = 0;

    // reference model state
    bit   m_busy = 0, m_pend = 0, m_isr = 0;
    int   m_left = 0;
    logic [15:0] pq[$];
    logic [19:0] aq[$], a2q[$];
    logic [31:0] lq[$], l2q[$];

    always #5 clk = ~clk;

    function automatic logic [15:0] fix_word(input logic [19:0] a);
        return (a == 20'h0) ? 16'h0100 : 16'h0000;
    endfunction

    function automatic logic [15:0] rnd_word(input logic [19:0] a, input logic [15:0] s);
        return (a[15:0] * 16'h9E37) ^ s ^ {12'h0, a[19:16]};
    endfunction

    function automatic logic [15:0] word(input logic [19:0] a);
        return fixed_mem ? fix_word(a) : rnd_word(a, mem_seed);
    endfunction

    assign mem_rdata  = fixed_mem ? fix_word(mem_addr)  : rnd_word(mem_addr, mem_seed);
    assign mem_rdata2 = fixed_mem ? fix_word(mem_addr2) : rnd_word(mem_addr2, mem_seed);

    interrupt_sequencer #(.DATA_WIDTH(16), .ADDR_WIDTH(20), .VEC_ADDR(20'h00000)) dut (
        .clk(clk), .rst(rst), .interrupt(interrupt), .inst_boundary(inst_boundary),
        .rti_done(rti_done), .resume_pc(resume_pc), .ccr(ccr), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .freeze(freeze), .push_en(push_en), .push_data(push_data),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .pc_load(pc_load),
        .pc_load_val(pc_load_val), .int_ack(int_ack), .in_isr(in_isr));

    interrupt_sequencer #(.DATA_WIDTH(16), .ADDR_WIDTH(20), .VEC_ADDR(20'hFFFFF)) dut_top (
        .clk(clk), .rst(rst), .interrupt(interrupt), .inst_boundary(inst_boundary),
        .rti_done(rti_done), .resume_pc(resume_pc), .ccr(ccr), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata2), .freeze(freeze2), .push_en(push_en2), .push_data(push_data2),
        .mem_rd_en(mem_rd_en2), .mem_addr(mem_addr2), .pc_load(pc_load2),
        .pc_load_val(pc_load_val2), .int_ack(int_ack2), .in_isr(in_isr2));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one entry = 3 pushes, 2 reads, 1 load cycle; each
    // access completes only on a cycle with mem_ready.
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_busy = 0; m_pend = 0; m_isr = 0; m_left = 0;
            pq.delete(); aq.delete(); a2q.delete(); lq.delete(); l2q.delete();
        end else if (!m_busy) begin
            if (m_pend && inst_boundary && !m_isr) begin
                m_busy = 1;
                m_left = 5;
                m_pend = interrupt;
                pq.push_back(resume_pc[15:0]);
                pq.push_back(resume_pc[31:16]);
                pq.push_back({13'h0, ccr});
                aq.push_back(20'h00000);  aq.push_back(20'h00001);
                a2q.push_back(20'hFFFFF); a2q.push_back(20'h00000);
                lq.push_back({word(20'h00001), word(20'h00000)});
                l2q.push_back({word(20'h00000), word(20'hFFFFF)});
            end else if (interrupt) begin
                m_pend = 1;
            end
            if (rti_done) m_isr = 0;
        end else begin
            if (interrupt) m_pend = 1;
            if (m_left == 0) begin
                m_busy = 0;
                m_isr  = 1;
            end else begin
                if (rti_done) m_isr = 0;
                if (mem_ready) m_left--;
            end
        end
    end

    // Monitor: compares DUT outputs against the model and expectation queues.
    initial forever begin
        bit load_ph;
        @(negedge clk);
        if (!rst) begin
            load_ph = m_busy && (m_left == 0);
            check("freeze", freeze, m_busy);
            check("freeze_top", freeze2, m_busy);
            check("in_isr", in_isr, m_isr || load_ph);
            check("push_en", push_en, m_busy && m_left > 2);
            check("mem_rd_en", mem_rd_en, m_busy && (m_left == 1 || m_left == 2));
            check("mem_rd_en_top", mem_rd_en2, m_busy && (m_left == 1 || m_left == 2));
            check("pc_load", pc_load, load_ph);
            check("int_ack", int_ack, load_ph);
            if (push_en) begin
                if (pq.size() == 0) check("push_unexpected", 1, 0);
                else begin
                    check("push_data", push_data, pq[0]);
                    check("push_data_top", push_data2, pq[0]);
                    if (mem_ready) begin void'(pq.pop_front()); pushes_seen++; end
                end
            end
            if (mem_rd_en) begin
                if (aq.size() == 0 || a2q.size() == 0) check("read_unexpected", 1, 0);
                else begin
                    check("mem_addr", mem_addr, aq[0]);
                    check("mem_addr_top", mem_addr2, a2q[0]);
                    if (mem_ready) begin void'(aq.pop_front()); void'(a2q.pop_front()); end
                end
            end
            if (pc_load) begin
                acks_seen++;
                if (lq.size() == 0 || l2q.size() == 0) check("load_unexpected", 1, 0);
                else begin
                    check("pc_load_val", pc_load_val, lq.pop_front());
                    check("pc_load_val_top", pc_load_val2, l2q.pop_front());
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input int limit, output int n);
        n = 0;
        do begin
            cyc();
            interrupt = 1'b0;
            n++;
        end while (!int_ack && n < limit);
        if (!int_ack) check("ack_timeout", 0, 1);
    endtask

    task automatic rti_pulse();
        rti_done = 1'b1;
        cyc();
        rti_done = 1'b0;
        cyc();
    endtask

    initial begin
        int n, a0, p0;
        bit found;
        #1;
        check("rst_freeze", freeze, 0);
        check("rst_push_en", push_en, 0);
        check("rst_in_isr", in_isr, 0);
        check("rst_pc_load_val", pc_load_val, 0);
        cyc(); cyc();
        rst = 1'b0;
        inst_boundary = 1'b1;
        cyc();

        // 1: basic entry
        resume_pc = 32'h0001_2345; ccr = 3'b101;
        interrupt = 1'b1;
        wait_ack(20, n);
        check("t1_ack_cycle", n, 7);
        check("t1_pc_load_val", pc_load_val, 32'h0000_0100);
        cyc(); cyc();
        rti_pulse();

        // 2: stalls in PUSH_PCH and FETCH_VL
        interrupt = 1'b1;
        n = 0;
        do begin
            cyc();
            interrupt = 1'b0;
            n++;
            mem_ready = !(n == 3 || n == 4 || n == 7 || n == 8);
        end while (!int_ack && n < 30);
        check("t2_ack_cycle", n, 11);
        mem_ready = 1'b1;
        cyc();
        rti_pulse();

        // 3: no boundary
        inst_boundary = 1'b0;
        interrupt = 1'b1;
        cyc();
        interrupt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("t3_freeze_idle", freeze, 0);
        end
        inst_boundary = 1'b1;
        cyc();
        check("t3_freeze_start", freeze, 1);
        wait_ack(20, n);
        cyc();
        rti_pulse();

        // 4: no nesting, coalescing
        a0 = acks_seen;
        interrupt = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cyc();
            interrupt = (i == 1 || i == 3 || i == 5);
        end
        check("t4_first_entry", acks_seen - a0, 1);
        for (int i = 0; i < 10; i++) begin
            interrupt = (i % 3 == 0);
            cyc();
        end
        interrupt = 1'b0;
        cyc();
        check("t4_no_nest_freeze", freeze, 0);
        check("t4_no_nest_acks", acks_seen - a0, 1);
        rti_pulse();
        for (int i = 0; i < 16; i++) cyc();
        check("t4_second_entry", acks_seen - a0, 2);
        rti_pulse();
        for (int i = 0; i < 12; i++) cyc();
        check("t4_exactly_once", acks_seen - a0, 2);

        // 5: reset in FETCH_VL
        interrupt = 1'b1;
        cyc();
        interrupt = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            cyc();
            if (mem_rd_en && mem_addr == 20'h0) found = 1;
        end
        check("t5_reached_fetch", found, 1);
        rst = 1'b1;
        #1;
        p0 = pushes_seen;
        check("t5_freeze", freeze, 0);
        check("t5_mem_rd_en", mem_rd_en, 0);
        check("t5_mem_addr", mem_addr, 0);
        check("t5_push_en", push_en, 0);
        check("t5_pc_load", pc_load, 0);
        cyc(); cyc();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            check("t5_idle_after_rst", freeze, 0);
        end
        check("t5_no_pushes", pushes_seen, p0);

        // random run
        fixed_mem = 1'b0;
        mem_seed = 16'($urandom);
        for (int i = 0; i < 3000; i++) begin
            interrupt     = ($urandom_range(0, 19) == 0);
            inst_boundary = ($urandom_range(0, 2) != 0);
            mem_ready     = ($urandom_range(0, 3) != 0);
            rti_done      = in_isr ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 49) == 0);
            resume_pc     = $urandom;
            ccr           = 3'($urandom_range(0, 7));
            cyc();
        end
        interrupt = 1'b0; rti_done = 1'b0; mem_ready = 1'b1; inst_boundary = 1'b1;
        for (int i = 0; i < 20; i++) cyc();
        check("drain_push_q", pq.size(), 0);
        check("drain_read_q", aq.size(), 0);
        check("drain_load_q", lq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
